ps2_kbd_decoder: RTL and testbench
==================================

# ps2_kbd_decoder

PS/2 keyboard decoder between the host PS/2 transceiver and the game logic. Consumes received bytes, runs the keyboard reset handshake after reset, and decodes scan-code set 2 sequences. Sequences include the E0 (extended) and F0 (break) prefixes. Produces one event per completed key sequence plus a live held-state vector for the Tetris control keys.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: clk cycles allowed between prefix and final byte, and per init-handshake wait.
- `MAX_RETRY`, default 3: number of init attempts before giving up.
- `INIT_EN`, default 1: 0 skips the init handshake and resets into IDLE.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous reset, active-high.
- `ps2_rddata_valid`, in, 1: one-cycle strobe, received byte available.
- `ps2_rd_data`, in, 8: received byte.
- `ps2_tx_ready`, in, 1: transmitter idle.
- `ps2_tx_done`, in, 1: one-cycle pulse, host-to-device byte finished.
- `ps2_wr_stb`, out, 1: one-cycle transmit request.
- `ps2_wr_data`, out, 8: byte to transmit; held stable while the request is outstanding.
- `key_valid`, out, 1: one-cycle event strobe.
- `key_code`, out, 8: final scan-code byte of the event.
- `key_ext`, out, 1: sequence contained E0.
- `key_break`, out, 1: release event (sequence contained F0).
- `key_state`, out, 5: held keys {drop, down, rotate, right, left}.
- `init_done`, out, 1: handshake finished, successfully or not.
- `init_fail`, out, 1: all retries exhausted.

## Operation
- States: INIT_SEND, INIT_WAIT_TX, INIT_WAIT_ACK, INIT_WAIT_BAT, IDLE, PRE_E0, PRE_F0, PRE_E0F0.
- Reset value of every output is 0. The state after reset is INIT_SEND when `INIT_EN`=1, otherwise IDLE with `init_done`=1.
- INIT_SEND: wait for `ps2_tx_ready`=1, then pulse `ps2_wr_stb` with `ps2_wr_data`=0xFF and go to INIT_WAIT_TX.
- INIT_WAIT_TX: on `ps2_tx_done`, go to INIT_WAIT_ACK.
- INIT_WAIT_ACK: byte 0xFA goes to INIT_WAIT_BAT. Any other byte, or timeout, is a retry.
- INIT_WAIT_BAT: byte 0xAA sets `init_done` and goes to IDLE. 0xFC, any other byte, or timeout is a retry.
- Retry: increment the attempt counter and return to INIT_SEND. When the counter reaches `MAX_RETRY`, set `init_done`=1 and `init_fail`=1, then go to IDLE.
- IDLE:
  - 0xE0 goes to PRE_E0.
  - 0xF0 goes to PRE_F0.
  - 0x00, 0xFF (overflow) or 0xAA (hot-plug BAT) clears `key_state`, emits no event, stays in IDLE.
  - 0xFA, 0xEE, 0xFE emit no event and stay in IDLE.
  - Any other byte emits a make event with ext=0.
- PRE_E0: 0xF0 goes to PRE_E0F0. 0x12 (fake shift) is dropped, back to IDLE. Any other byte emits a make event with ext=1.
- PRE_F0: next byte emits a break event with ext=0.
- PRE_E0F0: next byte emits a break event with ext=1, except 0x12, which is dropped.
- A prefix state with no byte for `TIMEOUT_CYCLES` returns to IDLE silently.
- Key map: left = E0 6B, right = E0 74, rotate = E0 75, down = E0 72, drop = 29 (ext=0). A make event on a mapped key sets its bit; a break clears it. Unmapped keys emit events only.

## Timing
- `key_valid` asserts the cycle after the `ps2_rddata_valid` that completes a sequence. `key_code`, `key_ext` and `key_break` are valid in that same cycle and hold until the next event.
- `key_state` updates in the same cycle as `key_valid`.
- `ps2_wr_stb` is issued only in a cycle where `ps2_tx_ready`=1, and at most once per attempt.
- A received byte arriving in INIT_SEND or INIT_WAIT_TX is ignored.
- The timeout counter is 20 bits minimum and sized from `TIMEOUT_CYCLES`. It clears on each state change and on each received byte.
- Asserting `rst` mid-sequence or mid-init returns immediately to the reset state and clears all outputs.

## Structure
- Shared package `ps2_pkg`: scan-code constants (E0, F0, FA, AA, FC, FF, 00, EE, FE, 12, 6B, 74, 75, 72, 29) and the `key_state` bit indices.
- One natural sub-module, `ps2_kbd_init`: the init FSM with its retry counter.
- The decode FSM, key map and timeout counter stay in the top module.

## Test plan
- Init OK: after reset, `ps2_tx_ready`=1 gives a single `ps2_wr_stb` with 0xFF. Then tx_done, FA, AA gives `init_done`=1 and `init_fail`=0.
- Init retry: reply FC three times gives three `ps2_wr_stb` pulses, then `init_done`=1 and `init_fail`=1.
- Extended make/break: E0 6B gives an event (6B, ext=1, break=0) and `key_state[0]`=1. E0 F0 6B gives break=1 and `key_state[0]`=0.
- Plain key plus overflow: 29 sets `key_state[4]`; a following 00 clears `key_state` with no `key_valid`.
- Prefix timeout: E0, then idle for `TIMEOUT_CYCLES`+1, then 75 gives an event with ext=0 and `key_state` unchanged.
- Fake shift and mid-run reset: E0 12 gives no event. E0 followed by `rst` pulsed low-high-low returns to the reset state, and 6B then gives no event while init is pending.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code set 2 constants, FSM state encoding and the Tetris key map
// used by the PS/2 keyboard decoder and its init sequencer.
package ps2_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FC = 8'hFC;
  localparam logic [7:0] SC_FF = 8'hFF;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_12 = 8'h12;
  localparam logic [7:0] SC_6B = 8'h6B;
  localparam logic [7:0] SC_74 = 8'h74;
  localparam logic [7:0] SC_75 = 8'h75;
  localparam logic [7:0] SC_72 = 8'h72;
  localparam logic [7:0] SC_29 = 8'h29;

  // Bit positions inside key_state = {drop, down, rotate, right, left}
  localparam int KEY_LEFT   = 0;
  localparam int KEY_RIGHT  = 1;
  localparam int KEY_ROTATE = 2;
  localparam int KEY_DOWN   = 3;
  localparam int KEY_DROP   = 4;

  typedef enum logic [2:0] {
    INIT_SEND,
    INIT_WAIT_TX,
    INIT_WAIT_ACK,
    INIT_WAIT_BAT,
    IDLE,
    PRE_E0,
    PRE_F0,
    PRE_E0F0
  } ps2_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_map_t;

  function automatic key_map_t key_lookup(input logic ext, input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.idx = 3'd0;
    if (ext) begin
      case (code)
        SC_6B:   m.idx = 3'(KEY_LEFT);
        SC_74:   m.idx = 3'(KEY_RIGHT);
        SC_75:   m.idx = 3'(KEY_ROTATE);
        SC_72:   m.idx = 3'(KEY_DOWN);
        default: m.hit = 1'b0;
      endcase
    end else if (code == SC_29) begin
      m.idx = 3'(KEY_DROP);
    end else begin
      m.hit = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_kbd_init.sv
// Keyboard reset handshake: sends 0xFF, expects ACK (FA) then BAT pass (AA),
// retrying up to MAX_RETRY attempts before reporting failure.
module ps2_kbd_init
  import ps2_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter bit INIT_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  input  logic       tx_done,
  input  logic       timeout,
  output logic       wr_stb,
  output logic [7:0] wr_data,
  output logic       init_done,
  output logic       init_fail,
  output ps2_state_e state,
  output ps2_state_e state_nxt
);

  localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] LAST_TRY = RETRY_W'(MAX_RETRY - 1);
  localparam ps2_state_e RESET_STATE = INIT_EN ? INIT_SEND : IDLE;

  ps2_state_e         state_q, state_d;
  logic [RETRY_W-1:0] attempt_q, attempt_d;
  logic               wr_stb_q, wr_stb_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               do_retry;

  always_comb begin
    state_d   = state_q;
    attempt_d = attempt_q;
    wr_stb_d  = 1'b0;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    fail_d    = fail_q;
    do_retry  = 1'b0;
    case (state_q)
      INIT_SEND: begin
        if (tx_ready) begin
          wr_stb_d  = 1'b1;
          wr_data_d = SC_FF;
          state_d   = INIT_WAIT_TX;
        end
      end
      INIT_WAIT_TX: begin
        if (tx_done)      state_d  = INIT_WAIT_ACK;
        else if (timeout) do_retry = 1'b1;
      end
      INIT_WAIT_ACK: begin
        if (rx_valid) begin
          if (rx_data == SC_FA) state_d  = INIT_WAIT_BAT;
          else                  do_retry = 1'b1;
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      INIT_WAIT_BAT: begin
        if (rx_valid) begin
          if (rx_data == SC_AA) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            do_retry = 1'b1;
          end
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      default: ;
    endcase
    if (do_retry) begin
      if (attempt_q >= LAST_TRY) begin
        done_d  = 1'b1;
        fail_d  = 1'b1;
        state_d = IDLE;
      end else begin
        attempt_d = attempt_q + 1'b1;
        state_d   = INIT_SEND;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      attempt_q <= '0;
      wr_stb_q  <= 1'b0;
      wr_data_q <= 8'h00;
      done_q    <= !INIT_EN;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      attempt_q <= attempt_d;
      wr_stb_q  <= wr_stb_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  // A request whose ready dropped is lost; the WAIT_TX timeout turns it into a retry.
  assign wr_stb    = wr_stb_q & tx_ready;
  assign wr_data   = wr_data_q;
  assign init_done = done_q;
  assign init_fail = fail_q;
  assign state     = state_q;
  assign state_nxt = state_d;

endmodule

// File: rtl/ps2_kbd_decoder.sv
// Scan-code set 2 decoder: E0/F0 prefix tracking, one event per completed
// sequence, held-state vector for the Tetris keys, and the shared timeout counter.
module ps2_kbd_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_RETRY      = 3,
  parameter bit INIT_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_rddata_valid,
  input  logic [7:0] ps2_rd_data,
  input  logic       ps2_tx_ready,
  input  logic       ps2_tx_done,
  output logic       ps2_wr_stb,
  output logic [7:0] ps2_wr_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [4:0] key_state,
  output logic       init_done,
  output logic       init_fail
);

  localparam int CNT_REQ = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_REQ > 20) ? CNT_REQ : 20;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  ps2_state_e init_state, init_state_nxt;
  ps2_state_e dec_state_q, dec_state_d;
  logic       state_chg, timeout_hit;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       valid_q, valid_d;
  logic [7:0] code_q, code_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [4:0] ks_q, ks_d;
  logic       emit, e_ext, e_brk;
  key_map_t   km;

  ps2_kbd_init #(
    .MAX_RETRY (MAX_RETRY),
    .INIT_EN   (INIT_EN)
  ) u_init (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (ps2_rddata_valid),
    .rx_data   (ps2_rd_data),
    .tx_ready  (ps2_tx_ready),
    .tx_done   (ps2_tx_done),
    .timeout   (timeout_hit),
    .wr_stb    (ps2_wr_stb),
    .wr_data   (ps2_wr_data),
    .init_done (init_done),
    .init_fail (init_fail),
    .state     (init_state),
    .state_nxt (init_state_nxt)
  );

  assign timeout_hit = (cnt_q >= CNT_LAST);

  // The counter belongs to whichever FSM currently owns the byte stream.
  always_comb begin
    if (init_done) state_chg = (dec_state_d != dec_state_q);
    else           state_chg = (init_state_nxt != init_state);
    if (ps2_rddata_valid || state_chg) cnt_d = '0;
    else if (cnt_q == CNT_MAX)         cnt_d = cnt_q;
    else                               cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    dec_state_d = dec_state_q;
    valid_d     = 1'b0;
    code_d      = code_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    ks_d        = ks_q;
    emit        = 1'b0;
    e_ext       = 1'b0;
    e_brk       = 1'b0;
    km          = key_lookup(1'b0, ps2_rd_data);
    if (init_done && ps2_rddata_valid) begin
      case (dec_state_q)
        IDLE: begin
          case (ps2_rd_data)
            SC_E0:               dec_state_d = PRE_E0;
            SC_F0:               dec_state_d = PRE_F0;
            SC_00, SC_FF, SC_AA: ks_d = '0;
            SC_FA, SC_EE, SC_FE: ;
            default:             emit = 1'b1;
          endcase
        end
        PRE_E0: begin
          if (ps2_rd_data == SC_F0) begin
            dec_state_d = PRE_E0F0;
          end else begin
            dec_state_d = IDLE;
            emit        = (ps2_rd_data != SC_12);
            e_ext       = 1'b1;
          end
        end
        PRE_F0: begin
          dec_state_d = IDLE;
          emit        = 1'b1;
          e_brk       = 1'b1;
        end
        PRE_E0F0: begin
          dec_state_d = IDLE;
          emit        = (ps2_rd_data != SC_12);
          e_ext       = 1'b1;
          e_brk       = 1'b1;
        end
        default: dec_state_d = IDLE;
      endcase
    end else if (init_done && timeout_hit && dec_state_q != IDLE) begin
      dec_state_d = IDLE;
    end
    if (emit) begin
      valid_d = 1'b1;
      code_d  = ps2_rd_data;
      ext_d   = e_ext;
      brk_d   = e_brk;
      km      = key_lookup(e_ext, ps2_rd_data);
      if (km.hit) ks_d[km.idx] = ~e_brk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_state_q <= IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      code_q      <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      ks_q        <= '0;
    end else begin
      dec_state_q <= dec_state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      ks_q        <= ks_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_ext   = ext_q;
  assign key_break = brk_q;
  assign key_state = ks_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: init handshake, retries, prefix decode,
// key-state tracking, prefix timeout and mid-sequence reset.
module tb_ps2_kbd_decoder;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_rddata_valid = 1'b0;
  logic [7:0] ps2_rd_data = 8'h00;
  logic       ps2_tx_ready = 1'b0;
  logic       ps2_tx_done = 1'b0;
  logic       ps2_wr_stb;
  logic [7:0] ps2_wr_data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [4:0] key_state;
  logic       init_done;
  logic       init_fail;

  int n_checks = 0;
  int n_pass   = 0;
  int stb_cnt  = 0;
  int evt_cnt  = 0;
  logic [9:0] exp_q[$];

  ps2_kbd_decoder #(
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRY      (3),
    .INIT_EN        (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ps2_rddata_valid (ps2_rddata_valid),
    .ps2_rd_data      (ps2_rd_data),
    .ps2_tx_ready     (ps2_tx_ready),
    .ps2_tx_done      (ps2_tx_done),
    .ps2_wr_stb       (ps2_wr_stb),
    .ps2_wr_data      (ps2_wr_data),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .key_ext          (key_ext),
    .key_break        (key_break),
    .key_state        (key_state),
    .init_done        (init_done),
    .init_fail        (init_fail)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // scoreboard: every key_valid must match the head of exp_q
  always @(posedge clk) begin
    logic [9:0] e;
    #1;
    if (ps2_wr_stb) begin
      stb_cnt++;
      check("wr_data", {24'h0, ps2_wr_data}, 32'hFF);
    end
    if (key_valid) begin
      evt_cnt++;
      check("evt_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("evt", {22'h0, key_ext, key_break, key_code}, {22'h0, e});
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2_rd_data      = b;
    ps2_rddata_valid = 1'b1;
    @(negedge clk);
    ps2_rddata_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    ps2_tx_done = 1'b1;
    @(negedge clk);
    ps2_tx_done = 1'b0;
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic wait_stb(input int base, input string tag);
    int k;
    k = 0;
    while (stb_cnt == base && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, stb_cnt - base, 1);
  endtask

  task automatic check_no_evt(input string tag, input int base);
    check(tag, evt_cnt - base, 0);
  endtask

  initial begin
    int base;

    // ---- reset state and successful init ----
    idle(3);
    check("rst_outs", {5'h0, ps2_wr_stb, ps2_wr_data, key_valid, key_code, key_ext,
                       key_break, key_state, init_done, init_fail}, 32'h0);
    rst = 1'b0;
    idle(5);
    check("no_stb_not_ready", stb_cnt, 0);
    ps2_tx_ready = 1'b1;
    base = stb_cnt;
    wait_stb(base, "init_stb");
    idle(5);
    check("single_stb", stb_cnt - base, 1);
    check("init_pending", init_done, 0);
    pulse_done();
    send_byte(8'hFA);
    send_byte(8'hAA);
    check("init_ok", {init_done, init_fail}, 2'b10);

    // ---- extended make / break ----
    expect_evt(1'b1, 1'b0, 8'h6B);
    send_byte(8'hE0); send_byte(8'h6B);
    check("ks_left_make", key_state, 5'b00001);
    expect_evt(1'b1, 1'b1, 8'h6B);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    check("ks_left_break", key_state, 5'b00000);

    // ---- plain drop key then overflow ----
    expect_evt(1'b0, 1'b0, 8'h29);
    send_byte(8'h29);
    check("ks_drop", key_state, 5'b10000);
    base = evt_cnt;
    send_byte(8'h00);
    idle(2);
    check("ks_cleared_00", key_state, 5'b00000);
    check_no_evt("no_evt_00", base);

    // ---- several held keys, cleared by FF ----
    expect_evt(1'b1, 1'b0, 8'h74);
    send_byte(8'hE0); send_byte(8'h74);
    check("ks_right", key_state, 5'b00010);
    expect_evt(1'b1, 1'b0, 8'h72);
    send_byte(8'hE0); send_byte(8'h72);
    expect_evt(1'b1, 1'b0, 8'h75);
    send_byte(8'hE0); send_byte(8'h75);
    check("ks_three", key_state, 5'b01110);
    base = evt_cnt;
    send_byte(8'hFF);
    idle(2);
    check("ks_cleared_ff", key_state, 5'b00000);
    check_no_evt("no_evt_ff", base);

    // ---- unmapped key, replies ignored ----
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C);
    expect_evt(1'b0, 1'b1, 8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    check("ks_unmapped", key_state, 5'b00000);
    base = evt_cnt;
    send_byte(8'hFA); send_byte(8'hEE); send_byte(8'hFE);
    idle(2);
    check_no_evt("no_evt_replies", base);

    // ---- prefix timeout ----
    expect_evt(1'b1, 1'b0, 8'h6B);
    send_byte(8'hE0); send_byte(8'h6B);
    send_byte(8'hE0);
    idle(TO + 2);
    expect_evt(1'b0, 1'b0, 8'h75);
    send_byte(8'h75);
    check("ks_after_timeout", key_state, 5'b00001);
    check("timeout_evt_ext", key_ext, 0);

    // ---- fake shift ----
    base = evt_cnt;
    send_byte(8'hE0); send_byte(8'h12);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
    idle(2);
    check_no_evt("no_evt_fake_shift", base);
    expect_evt(1'b1, 1'b1, 8'h6B);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    check("ks_left_release", key_state, 5'b00000);
    check("events_drained_a", exp_q.size(), 0);

    // ---- init retry exhaustion ----
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    base = stb_cnt;
    for (int i = 0; i < 3; i++) begin
      wait_stb(base + i, "retry_stb");
      pulse_done();
      send_byte(8'hFC);
    end
    idle(5);
    check("retry_stb_total", stb_cnt - base, 3);
    check("init_failed", {init_done, init_fail}, 2'b11);

    // ---- mid-sequence reset ----
    expect_evt(1'b0, 1'b0, 8'h29);
    send_byte(8'h29);
    check("ks_drop_after_fail", key_state, 5'b10000);
    ps2_tx_ready = 1'b0;
    send_byte(8'hE0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    check("midrun_rst_outs", {5'h0, ps2_wr_stb, ps2_wr_data, key_valid, key_code, key_ext,
                              key_break, key_state, init_done, init_fail}, 32'h0);
    rst = 1'b0;
    idle(2);
    base = evt_cnt;
    send_byte(8'h6B);
    idle(3);
    check_no_evt("no_evt_init_pending", base);
    check("init_pending_again", {init_done, init_fail}, 2'b00);
    check("ks_after_rst", key_state, 5'b00000);
    check("events_drained_b", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
